dmem_waitstate: RTL and testbench

Data-memory block for the single-cycle MIPS core, sitting directly downstream of the datapath. It consumes the datapath's ALU result as the byte address, its store data and the controller's memread/memwrite strobes. It returns load data for the result mux. A wait-state FSM emulates a slow memory with a programmable latency and raises `stall`; while `stall` is high the datapath must freeze the PC and suppress all architectural writes.

---
 rtl/dmem_waitstate.sv | 81 ++++++++
 tb/tb_dmem_waitstate.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dmem_waitstate.sv
// dmem_waitstate: word-addressed data memory with a programmable wait-state stall.
// A request takes exactly LAT stall cycles followed by one DONE completion cycle.
module dmem_waitstate #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LAT        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  misalign_q;
    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
    logic                  req, mis, done;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           word;
    logic                  unused_addr;

    assign req         = memread | memwrite;
    assign idx         = addr[DEPTH_LOG2+1:2];
    assign mis         = addr[1:0] != 2'b00;
    assign word        = mis ? 32'd0 : mem[idx];
    assign unused_addr = ^addr[31:DEPTH_LOG2+2];
    // With zero latency the completion cycle is the IDLE request cycle itself
    assign done        = !reset && req && (state_q == DONE || (state_q == IDLE && LAT == 0));
    assign readdata    = (LAT == 0) ? word : rdata_q;
    assign misalign    = misalign_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req && LAT != 0;
                if (req && LAT != 0) begin
                    cnt_d   = LAT_M1;
                    state_d = (LAT == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall   = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                state_d = !req ? IDLE : (cnt_q == 4'd1) ? DONE : WAIT;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE) rdata_d = word;
        if (reset) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (done && mis) misalign_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (done && memwrite && !mis) mem[idx] <= writedata;
    end
endmodule

// File: tb/tb_dmem_waitstate.sv
// tb_dmem_waitstate: drives one instance per latency 0..4 against a transaction-level memory model.
module tb_dmem_waitstate;
    logic        clk = 1'b0;
    logic        rst [5];
    logic        mr  [5];
    logic        mw  [5];
    logic [31:0] ad  [5];
    logic [31:0] wd  [5];
    logic [31:0] rdv [5];
    logic        stv [5];
    logic        mav [5];
    logic [31:0] mdl [5][64];
    logic        mis [5];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        dmem_waitstate #(.DEPTH_LOG2(6), .LAT(g)) u_dut (
            .clk(clk), .reset(rst[g]), .memread(mr[g]), .memwrite(mw[g]),
            .addr(ad[g]), .writedata(wd[g]), .readdata(rdv[g]),
            .stall(stv[g]), .misalign(mav[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("stall_idle", 32'(stv[k]), 32'd0);
            chk("misalign_idle", 32'(mav[k]), 32'(mis[k]));
            @(posedge clk); #1;
        end
    endtask

    // hold < 0: full access; otherwise drop the request after hold stalled cycles
    task automatic access(input int k, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        int   idx = int'(a[7:2]);
        logic al  = (a[1:0] == 2'b00);
        int   n   = (hold < 0) ? k : hold;
        mr[k] = rd; mw[k] = wr; ad[k] = a; wd[k] = d;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("stall_wait", 32'(stv[k]), 32'd1);
            @(posedge clk); #1;
        end
        if (hold >= 0) begin
            mr[k] = 1'b0; mw[k] = 1'b0;
            @(negedge clk);
            chk("stall_abort", 32'(stv[k]), 32'd1);
            chk("misalign_abort", 32'(mav[k]), 32'(mis[k]));
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        chk("stall_done", 32'(stv[k]), 32'd0);
        if (rd && !wr) chk("readdata", rdv[k], al ? mdl[k][idx] : 32'd0);
        chk("misalign_done", 32'(mav[k]), 32'(mis[k]));
        @(posedge clk); #1;
        if (wr && al) mdl[k][idx] = d;
        if (!al) mis[k] = 1'b1;
        mr[k] = 1'b0; mw[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) begin
            rst[k] = 1'b1; mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = 32'd0; wd[k] = 32'd0; mis[k] = 1'b0;
        end
        mr[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_in_reset", 32'(stv[2]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("misalign_rst", 32'(mav[k]), 32'd0);
            if (k > 0) chk("readdata_rst", rdv[k], 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) rst[k] = 1'b0;
        mr[2] = 1'b0;

        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 64; i++)
                access(k, 1'b0, 1'b1, {$urandom_range(0, 255), 24'd0} | 32'(i << 2), $urandom, -1);

        access(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1);
        access(2, 1'b1, 1'b0, 32'h10, 32'h0, -1);
        access(0, 1'b0, 1'b1, 32'h04, 32'h12345678, -1);
        access(0, 1'b1, 1'b0, 32'h04, 32'h0, -1);
        access(3, 1'b1, 1'b0, 32'h22, 32'h0, -1);
        idle(3, 10);
        access(3, 1'b0, 1'b1, 32'h22, 32'hCAFEF00D, -1);
        access(3, 1'b1, 1'b0, 32'h20, 32'h0, -1);
        access(2, 1'b0, 1'b1, 32'h104, 32'hA5A5A5A5, -1);
        access(2, 1'b1, 1'b0, 32'h004, 32'h0, -1);
        access(2, 1'b1, 1'b1, 32'h0C, 32'h0000FFFF, -1);
        access(2, 1'b1, 1'b0, 32'h0C, 32'h0, -1);
        access(3, 1'b0, 1'b1, 32'h30, 32'h11112222, 2);
        idle(3, 1);
        access(3, 1'b1, 1'b0, 32'h30, 32'h0, -1);

        access(4, 1'b1, 1'b0, 32'h41, 32'h0, -1);
        mw[4] = 1'b1; ad[4] = 32'h08; wd[4] = 32'h55AA55AA;
        @(negedge clk);
        chk("stall_rst_c0", 32'(stv[4]), 32'd1);
        @(posedge clk); #1;
        rst[4] = 1'b1;
        @(negedge clk);
        chk("stall_rst_c1", 32'(stv[4]), 32'd0);
        @(posedge clk); #1;
        rst[4] = 1'b0; mw[4] = 1'b0; mis[4] = 1'b0;
        @(negedge clk);
        chk("stall_after_rst", 32'(stv[4]), 32'd0);
        chk("misalign_after_rst", 32'(mav[4]), 32'd0);
        chk("readdata_after_rst", rdv[4], 32'd0);
        @(posedge clk); #1;
        access(4, 1'b1, 1'b0, 32'h08, 32'h0, -1);

        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < 60; t++) begin
                int          op  = $urandom_range(0, 2);
                logic [31:0] a   = $urandom;
                int          hld = -1;
                if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
                if (k >= 2 && $urandom_range(0, 7) == 0) hld = $urandom_range(1, k - 1);
                access(k, op != 1, op != 0, a, $urandom, hld);
                idle(k, $urandom_range(0, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
